// File: rtl/jump_charge.sv
// Jump button charger: measures how long the button is held and presents the
// saturated distance to the game fsm for a fixed hold window. Optional lockout
// until end_of_jump is enabled by the JUMP_LOCKOUT_EN macro.
module jump_charge #(
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned MAX_DIST    = 30,
  parameter int unsigned HOLD_CYCLES = 2097152
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       jump_btn,
  input  logic       end_of_jump,
  output logic [7:0] jump_dist,
  output logic       charging,
  output logic       saturated,
  output logic       busy
);

  localparam int unsigned DIST_W  = 8;
  localparam int unsigned PRESC_W = 24;
  localparam int unsigned HOLD_W  = 24;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIST_W-1:0]  DIST_MAX   = DIST_W'(MAX_DIST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHARGE = 2'd1,
    S_FIRE   = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DIST_W-1:0]   count_q, count_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIST_W-1:0]   dist_d;
  logic                btn_q;
  logic                press;

`ifdef JUMP_LOCKOUT_EN
  logic eoj_q, eoj_d;
`else
  logic unused_eoj;
  assign unused_eoj = end_of_jump;
`endif

  assign press = jump_btn & ~btn_q;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    dist_d  = jump_dist;
`ifdef JUMP_LOCKOUT_EN
    eoj_d   = eoj_q;
`endif
    case (state_q)
      S_IDLE: begin
        dist_d = '0;
        if (press) begin
          count_d = '0;
          presc_d = '0;
          state_d = S_CHARGE;
        end
      end
      S_CHARGE: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (count_q < DIST_MAX) count_d = count_q + DIST_W'(1);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        // Release latches the post-increment count so a coincident tick is kept
        if (!jump_btn) begin
          if (count_d == '0) begin
            state_d = S_IDLE;
          end else begin
            dist_d  = count_d;
            hold_d  = '0;
            state_d = S_FIRE;
`ifdef JUMP_LOCKOUT_EN
            eoj_d   = 1'b0;
`endif
          end
        end
      end
      S_FIRE: begin
`ifdef JUMP_LOCKOUT_EN
        eoj_d = eoj_q | end_of_jump;
`endif
        if (hold_q == HOLD_LAST) begin
          dist_d = '0;
`ifdef JUMP_LOCKOUT_EN
          // A pulse in the final hold cycle still counts, otherwise LOCK would never exit
          state_d = (eoj_q | end_of_jump) ? S_IDLE : S_LOCK;
`else
          state_d = S_IDLE;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
`ifdef JUMP_LOCKOUT_EN
      S_LOCK: begin
        dist_d = '0;
        if (end_of_jump) state_d = S_IDLE;
      end
`endif
      default: begin
        dist_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    // Tracks the button even in reset so a press held through clr is not an edge
    btn_q <= jump_btn;
    if (clr) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      hold_q    <= '0;
      jump_dist <= '0;
      charging  <= 1'b0;
      saturated <= 1'b0;
      busy      <= 1'b0;
`ifdef JUMP_LOCKOUT_EN
      eoj_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      jump_dist <= dist_d;
      charging  <= (state_d == S_CHARGE);
      saturated <= (state_d == S_CHARGE) && (count_d == DIST_MAX);
      busy      <= (state_d == S_FIRE) || (state_d == S_LOCK);
`ifdef JUMP_LOCKOUT_EN
      eoj_q     <= eoj_d;
`endif
    end
  end

endmodule

// File: tb/tb_jump_charge.sv
// Randomized self-checking bench for jump_charge against a behavioural model
// that derives the count from elapsed charge cycles.
module tb_jump_charge;

  localparam int TICK = 4;
  localparam int MAXD = 20;
  localparam int HOLD = 8;
`ifdef JUMP_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  localparam int M_IDLE   = 0;
  localparam int M_CHARGE = 1;
  localparam int M_FIRE   = 2;
  localparam int M_LOCK   = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       jump_btn = 1'b0;
  logic       end_of_jump = 1'b0;
  logic [7:0] jump_dist;
  logic       charging;
  logic       saturated;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_mode = M_IDLE;
  int m_k    = 0;
  int m_dist = 0;
  int m_left = 0;
  bit m_seen = 1'b0;
  bit m_prev = 1'b0;

  jump_charge #(
    .TICK_DIV   (TICK),
    .MAX_DIST   (MAXD),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .jump_btn   (jump_btn),
    .end_of_jump(end_of_jump),
    .jump_dist  (jump_dist),
    .charging   (charging),
    .saturated  (saturated),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dist_of(input int k);
    int c;
    c = k / TICK;
    return (c > MAXD) ? MAXD : c;
  endfunction

  task automatic model_step(input bit c, input bit b, input bit e);
    if (c) begin
      m_mode = M_IDLE;
      m_k    = 0;
      m_dist = 0;
      m_left = 0;
      m_seen = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (b && !m_prev) begin
          m_mode = M_CHARGE;
          m_k    = 0;
        end
        M_CHARGE: begin
          if (m_k < TICK * MAXD) m_k++;
          if (!b) begin
            if (dist_of(m_k) == 0) m_mode = M_IDLE;
            else begin
              m_dist = dist_of(m_k);
              m_left = HOLD;
              m_seen = 1'b0;
              m_mode = M_FIRE;
            end
          end
        end
        M_FIRE: begin
          m_seen = m_seen | e;
          m_left--;
          if (m_left == 0) begin
            m_dist = 0;
            m_mode = (LOCKOUT && !m_seen) ? M_LOCK : M_IDLE;
          end
        end
        default: if (e) m_mode = M_IDLE;
      endcase
    end
    m_prev = b;
  endtask

  task automatic step(input bit c, input bit b, input bit e);
    clr = c;
    jump_btn = b;
    end_of_jump = e;
    @(posedge clk);
    model_step(c, b, e);
    #1;
    check("jump_dist", 32'(jump_dist), 32'(m_dist));
    check("charging", 32'(charging), 32'(m_mode == M_CHARGE));
    check("saturated", 32'(saturated), 32'((m_mode == M_CHARGE) && (dist_of(m_k) == MAXD)));
    check("busy", 32'(busy), 32'((m_mode == M_FIRE) || (m_mode == M_LOCK)));
  endtask

  task automatic run(input int n, input bit c, input bit b, input bit e);
    for (int i = 0; i < n; i++) step(c, b, e);
  endtask

  initial begin
    bit btn;
    int runlen;

    // Reset with the button held: no charge afterwards
    run(2, 1'b1, 1'b1, 1'b0);
    check("rst_dist", 32'(jump_dist), 32'd0);
    run(5, 1'b0, 1'b1, 1'b0);
    check("no_edge_charge", 32'(charging), 32'd0);
    run(3, 1'b0, 1'b0, 1'b0);

    // 62-cycle press yields 15
    run(62, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("dist15", 32'(jump_dist), 32'd15);
    run(12, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0);

    // Long press saturates
    run(200, 1'b0, 1'b1, 1'b0);
    check("sat_high", 32'(saturated), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("dist20", 32'(jump_dist), 32'd20);
    run(9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);

    // Short tap: no jump
    run(3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("tap_busy", 32'(busy), 32'd0);
    check("tap_dist", 32'(jump_dist), 32'd0);
    run(3, 1'b0, 1'b0, 1'b0);

    // Lockout behaviour
    run(40, 1'b0, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1, 1'b0);
    check("held_no_charge", 32'(charging), 32'd0);
    run(2, 1'b0, 1'b0, 1'b0);
    run(20, 1'b0, 1'b1, 1'b0);
    check("repress_charge", 32'(charging), 32'd1);
    run(3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run(6, 1'b0, 1'b0, 1'b0);
    check("fire_eoj_idle", 32'(busy), 32'd0);

    // Clear mid-charge and mid-fire
    run(30, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("clr_charge", 32'(charging), 32'd0);
    run(2, 1'b0, 1'b0, 1'b0);
    run(30, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("clr_fire_dist", 32'(jump_dist), 32'd0);
    run(4, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    btn = 1'b0;
    runlen = 0;
    for (int i = 0; i < 2500; i++) begin
      if (runlen == 0) begin
        btn = ~btn;
        runlen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 120);
      end
      runlen--;
      step(($urandom_range(0, 299) == 0), btn, ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
